register_file: RTL and testbench
================================

// Module: register_file
//
// PURPOSE
// - General-purpose register file for the 16-bit RISC datapath: 8 x 16-bit registers.
// - Two independent combinational read ports feed the ALU operand stage.
// - One synchronous write port is driven by the write-back stage.
// - flush clears every register; it doubles as the block's reset.
//
// PARAMETERS
// - DATA_WIDTH  16  width of each register and of every data port
// - ADDR_WIDTH  3   register address width
// - NUM_REGS    8   register count; fixed at 2**ADDR_WIDTH
//
// PORTS
// - clock       in   1           single clock; all state updates on its rising edge
// - flush       in   1           reset: synchronous, active-high; clears all registers
// - read_adr_1  in   ADDR_WIDTH  address for read port 1
// - read_adr_2  in   ADDR_WIDTH  address for read port 2
// - write_data  in   DATA_WIDTH  data to write
// - write_adr   in   ADDR_WIDTH  destination register address
// - write_en    in   1           write enable, active-high
// - data_out_1  out  DATA_WIDTH  contents of register read_adr_1
// - data_out_2  out  DATA_WIDTH  contents of register read_adr_2
//
// BEHAVIOUR
// - Storage: NUM_REGS registers of DATA_WIDTH bits.
//   - All registers, including r0, are writable; none is hardwired to zero.
// - Reset: flush=1 at a rising clock edge sets every register to 16'h0000.
//   - Both outputs read 0 from that edge onward, for any addresses.
//   - flush has no asynchronous effect.
// - Write: flush=0 and write_en=1 at a rising edge stores write_data in reg[write_adr].
//   - Other registers are unchanged.
//   - write_en=0: no register changes.
// - Flush and write in the same cycle: flush wins; the write is discarded.
// - Read: data_out_n = reg[read_adr_n], purely combinational, zero-cycle latency.
//   - Outputs follow address changes within the same cycle.
//   - Both ports may address the same register; both then return the same value.
// - Read during write to the same address: there is no internal bypass.
//   - The output shows the old value until the rising edge.
//   - It shows the new value immediately after the edge.
//   - Forwarding is the pipeline's responsibility.
// - Power-up before the first flush: contents are undefined (X in simulation).
//   - The system must assert flush before use.
// - Inputs sampled only at the rising edge; glitches between edges have no effect on state.
// - No handshake and no busy state: a write is accepted every cycle.
//
// STRUCTURE
// - Shared package cpu_pkg holds:
//   - DATA_WIDTH (16), REG_ADDR_WIDTH (3), NUM_REGS (8)
//   - typedefs word_t (16-bit) and reg_addr_t (3-bit)
// - Storage array plus write logic live in this module.
// - One natural sub-module: regfile_read_port.
//   - Combinational NUM_REGS:1 mux, instantiated twice.
//
// TESTING
// 1. Flush: write r0..r7 with distinct values, pulse flush for one edge -> all 8 registers read 0.
// 2. Write/read: write r0=16'h3131, r3=16'h6969, r5=16'h0FF0 on successive edges.
//    - read_adr_1=0 -> 3131; read_adr_2=3 -> 6969; read_adr_1=5 -> 0FF0.
// 3. Read timing: write_en=1, write_adr=3, write_data=16'hABCD, read_adr_1=3.
//    - Before the edge data_out_1=6969; after the edge ABCD (no bypass).
// 4. Priority: flush=1 and write_en=1 (r2=16'h1234) in the same cycle -> r2 reads 0 afterwards.
// 5. Enable gating: write_en=0, write_adr=5, write_data=16'hFFFF across several edges -> r5 keeps 0FF0.
// 6. Dual port: read_adr_1=read_adr_2=5 -> both outputs 0FF0.
//    - Then sweep both addresses 0..7 and check every output against a reference model.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath types and sizing for the 16-bit RISC core.
// Register file geometry lives here so the pipeline stages agree on widths.
package cpu_pkg;

   localparam int DATA_WIDTH     = 16;
   localparam int REG_ADDR_WIDTH = 3;
   localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0]     word_t;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage : cpu_pkg

// File: rtl/regfile_read_port.sv
// Combinational NUM_REGS:1 read mux for the register file.
// Zero-cycle latency: the output follows the address within the same cycle.
module regfile_read_port
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
   parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] i_regs,
   input  logic [ADDR_WIDTH-1:0]               i_adr,
   output logic [DATA_WIDTH-1:0]               o_data
);

   logic [DATA_WIDTH-1:0] w_sel;

   always_comb begin
      w_sel = i_regs[i_adr];
   end

   assign o_data = w_sel;

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 8 x 16-bit general-purpose register file: two combinational read ports,
// one synchronous write port, synchronous flush that clears every register.
module register_file
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
   parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] read_adr_1,
   input  logic [ADDR_WIDTH-1:0] read_adr_2,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] write_adr,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] data_out_1,
   output logic [DATA_WIDTH-1:0] data_out_2
);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;

   // No read bypass: a same-cycle write becomes visible only after the edge;
   // forwarding is handled by the pipeline. Flush takes priority over a write.
   always_ff @(posedge clock) begin
      if (flush) begin
         r_regs <= '0;
      end else if (write_en) begin
         r_regs[write_adr] <= write_data;
      end
   end

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_rd_port_1 (
      .i_regs (r_regs),
      .i_adr  (read_adr_1),
      .o_data (data_out_1)
   );

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_rd_port_2 (
      .i_regs (r_regs),
      .i_adr  (read_adr_2),
      .o_data (data_out_2)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against an array model of the eight registers.
module tb_register_file;

   logic        clock;
   logic        flush;
   logic [2:0]  read_adr_1;
   logic [2:0]  read_adr_2;
   logic [15:0] write_data;
   logic [2:0]  write_adr;
   logic        write_en;
   logic [15:0] data_out_1;
   logic [15:0] data_out_2;

   logic [15:0] model [8];
   int checks;
   int failures;

   register_file dut (
      .clock      (clock),
      .flush      (flush),
      .read_adr_1 (read_adr_1),
      .read_adr_2 (read_adr_2),
      .write_data (write_data),
      .write_adr  (write_adr),
      .write_en   (write_en),
      .data_out_1 (data_out_1),
      .data_out_2 (data_out_2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and apply the architectural rules to the model.
   task automatic tick();
      @(posedge clock);
      if (flush) begin
         for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      end else if (write_en) begin
         model[write_adr] = write_data;
      end
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; write_en = 1'b0;
   endtask

   task automatic test_reset();
      // distinct values in every register, then one flush edge
      for (int i = 0; i < 8; i++) begin
         write_en = 1'b1; write_adr = 3'(i); write_data = 16'h1000 + 16'(i * 16'h0111);
         tick();
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         read_adr_1 = 3'(i); #1;
         checks++;
         if (data_out_1 !== 16'h1000 + 16'(i * 16'h0111)) begin
            failures++;
            $display("FAIL reset_prefill r%0d got=%h exp=%h", i, data_out_1, 16'h1000 + 16'(i * 16'h0111));
         end
      end
      // flush raised mid-cycle must not change anything before the edge
      flush = 1'b1; read_adr_1 = 3'd7; #1;
      checks++;
      if (data_out_1 !== 16'h1777) begin
         failures++;
         $display("FAIL flush_async got=%h exp=1777", data_out_1);
      end
      tick();
      flush = 1'b0;
      for (int i = 0; i < 8; i++) begin
         read_adr_1 = 3'(i); read_adr_2 = 3'(7 - i); #1;
         checks++;
         if (data_out_1 !== 16'h0000 || data_out_2 !== 16'h0000) begin
            failures++;
            $display("FAIL reset_clear r%0d got=%h/%h exp=0000/0000", i, data_out_1, data_out_2);
         end
      end
   endtask

   task automatic test_write_read();
      write_en = 1'b1;
      write_adr = 3'd0; write_data = 16'h3131; tick();
      write_adr = 3'd3; write_data = 16'h6969; tick();
      write_adr = 3'd5; write_data = 16'h0FF0; tick();
      idle();
      read_adr_1 = 3'd0; read_adr_2 = 3'd3; #1;
      checks++;
      if (data_out_1 !== 16'h3131) begin
         failures++; $display("FAIL wr_r0 got=%h exp=3131", data_out_1);
      end
      checks++;
      if (data_out_2 !== 16'h6969) begin
         failures++; $display("FAIL wr_r3 got=%h exp=6969", data_out_2);
      end
      read_adr_1 = 3'd5; #1;
      checks++;
      if (data_out_1 !== 16'h0FF0) begin
         failures++; $display("FAIL wr_r5 got=%h exp=0FF0", data_out_1);
      end
      read_adr_1 = 3'd1; #1;
      checks++;
      if (data_out_1 !== 16'h0000) begin
         failures++; $display("FAIL wr_untouched_r1 got=%h exp=0000", data_out_1);
      end
   endtask

   task automatic test_read_timing();
      write_en = 1'b1; write_adr = 3'd3; write_data = 16'hABCD; read_adr_1 = 3'd3; #1;
      checks++;
      if (data_out_1 !== 16'h6969) begin
         failures++; $display("FAIL rdw_before got=%h exp=6969", data_out_1);
      end
      tick();
      idle();
      checks++;
      if (data_out_1 !== 16'hABCD) begin
         failures++; $display("FAIL rdw_after got=%h exp=ABCD", data_out_1);
      end
   endtask

   task automatic test_enable_gating();
      write_en = 1'b0; write_adr = 3'd5; write_data = 16'hFFFF; read_adr_1 = 3'd5;
      for (int k = 0; k < 4; k++) begin
         // glitch write_en between edges; only the edge-sampled value counts
         write_en = 1'b1; #1; write_en = 1'b0;
         tick();
         checks++;
         if (data_out_1 !== 16'h0FF0) begin
            failures++; $display("FAIL en_gate cycle%0d got=%h exp=0FF0", k, data_out_1);
         end
      end
   endtask

   task automatic test_dual_port();
      read_adr_1 = 3'd5; read_adr_2 = 3'd5; #1;
      checks++;
      if (data_out_1 !== 16'h0FF0 || data_out_2 !== 16'h0FF0) begin
         failures++; $display("FAIL dual_same got=%h/%h exp=0FF0/0FF0", data_out_1, data_out_2);
      end
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            read_adr_1 = 3'(a); read_adr_2 = 3'(b); #1;
            checks++;
            if (data_out_1 !== model[a] || data_out_2 !== model[b]) begin
               failures++;
               $display("FAIL dual_sweep a=%0d b=%0d got=%h/%h exp=%h/%h",
                        a, b, data_out_1, data_out_2, model[a], model[b]);
            end
         end
      end
   endtask

   task automatic test_priority();
      write_en = 1'b1; write_adr = 3'd2; write_data = 16'h5555; tick();
      flush = 1'b1; write_en = 1'b1; write_adr = 3'd2; write_data = 16'h1234; tick();
      idle();
      read_adr_1 = 3'd2; read_adr_2 = 3'd5; #1;
      checks++;
      if (data_out_1 !== 16'h0000) begin
         failures++; $display("FAIL prio_r2 got=%h exp=0000", data_out_1);
      end
      checks++;
      if (data_out_2 !== 16'h0000) begin
         failures++; $display("FAIL prio_r5 got=%h exp=0000", data_out_2);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         flush      = ($urandom_range(0, 15) == 0);
         write_en   = ($urandom_range(0, 3) != 0);
         write_adr  = 3'($urandom_range(0, 7));
         write_data = 16'($urandom);
         read_adr_1 = 3'($urandom_range(0, 7));
         read_adr_2 = 3'($urandom_range(0, 7));
         #1;
         checks++;
         if (data_out_1 !== model[read_adr_1] || data_out_2 !== model[read_adr_2]) begin
            failures++;
            $display("FAIL rand_pre n=%0d a=%0d b=%0d got=%h/%h exp=%h/%h", n, read_adr_1,
                     read_adr_2, data_out_1, data_out_2, model[read_adr_1], model[read_adr_2]);
         end
         tick();
         checks++;
         if (data_out_1 !== model[read_adr_1] || data_out_2 !== model[read_adr_2]) begin
            failures++;
            $display("FAIL rand_post n=%0d a=%0d b=%0d got=%h/%h exp=%h/%h", n, read_adr_1,
                     read_adr_2, data_out_1, data_out_2, model[read_adr_1], model[read_adr_2]);
         end
      end
      idle();
   endtask

   initial begin
      checks = 0; failures = 0;
      flush = 1'b1; write_en = 1'b0; write_adr = '0; write_data = '0;
      read_adr_1 = '0; read_adr_2 = '0;
      for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
      tick();
      tick();
      flush = 1'b0;
      test_reset();
      test_write_read();
      test_read_timing();
      test_enable_gating();
      test_dual_port();
      test_priority();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_register_file
